// File: rtl/pc_redirect.sv
// Fetch PC register and redirect controller: resolves branch/JAL/JALR targets,
// defers redirects under stall, flushes wrong-path fetch, traps misaligned targets.
module pc_redirect #(
   parameter logic [31:0] ResetVector = 32'h0000_2000,
   parameter logic [31:0] TrapVector  = 32'h0000_0100,
   parameter int          FlushCycles = 2,
   parameter int          CountWidth  = 16
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_stall,
   input  logic                  i_ex_valid,
   input  logic                  i_ex_is_branch,
   input  logic                  i_ex_is_jal,
   input  logic                  i_ex_is_jalr,
   input  logic                  i_diverge,
   input  logic [31:0]           i_ex_pc,
   input  logic [31:0]           i_ex_imm,
   input  logic [31:0]           i_ex_rs1,
   output logic [31:0]           o_pc,
   output logic                  o_flush,
   output logic                  o_trap,
   output logic [31:0]           o_trap_pc,
   output logic [CountWidth-1:0] o_redirect_count
);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_PENDING = 2'd1,
      S_FLUSH   = 2'd2
   } state_t;

   localparam logic [2:0] LP_FLUSH_LOAD = 3'(FlushCycles);

   state_t                r_state;
   state_t                w_state_next;
   logic [31:0]           r_pc;
   logic [31:0]           r_pend_pc;
   logic [31:0]           r_pend_ex_pc;
   logic                  r_pend_trap;
   logic [2:0]            r_flush_cnt;
   logic                  r_trap;
   logic [31:0]           r_trap_pc;
   logic [CountWidth-1:0] r_count;

   logic                  w_req;
   logic [31:0]           w_target;
   logic                  w_misaligned;
   logic [31:0]           w_dest;
   logic                  w_accept;
   logic                  w_latch;
   logic [31:0]           w_acc_pc;
   logic [31:0]           w_acc_ex_pc;
   logic                  w_acc_trap;

   // JALR outranks JAL/branch when upstream illegally raises several indicators
   always_comb begin
      w_req = i_ex_valid & ((i_ex_is_branch & i_diverge) | i_ex_is_jal | i_ex_is_jalr);
      if (i_ex_is_jalr) begin
         w_target = (i_ex_rs1 + i_ex_imm) & ~32'h1;
      end else begin
         w_target = i_ex_pc + i_ex_imm;
      end
      w_misaligned = |w_target[1:0];
      w_dest       = w_misaligned ? TrapVector : w_target;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_RUN: begin
            if (w_req) begin
               w_state_next = i_stall ? S_PENDING : S_FLUSH;
            end
         end
         S_PENDING: begin
            if (!i_stall) begin
               w_state_next = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (!i_stall && r_flush_cnt == 3'd1) begin
               w_state_next = S_RUN;
            end
         end
         default: w_state_next = S_RUN;
      endcase
   end

   // A deferred redirect replays the values captured when it first arrived
   always_comb begin
      w_accept    = ((r_state == S_RUN) & w_req & ~i_stall) | ((r_state == S_PENDING) & ~i_stall);
      w_latch     = (r_state == S_RUN) & w_req & i_stall;
      w_acc_pc    = (r_state == S_PENDING) ? r_pend_pc    : w_dest;
      w_acc_ex_pc = (r_state == S_PENDING) ? r_pend_ex_pc : i_ex_pc;
      w_acc_trap  = (r_state == S_PENDING) ? r_pend_trap  : w_misaligned;
      o_flush     = (r_state == S_FLUSH);
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pc         <= ResetVector;
         r_pend_pc    <= 32'h0;
         r_pend_ex_pc <= 32'h0;
         r_pend_trap  <= 1'b0;
         r_flush_cnt  <= 3'd0;
         r_trap       <= 1'b0;
         r_trap_pc    <= 32'h0;
         r_count      <= '0;
      end else begin
         r_trap <= w_accept & w_acc_trap;
         if (w_accept) begin
            r_pc        <= w_acc_pc;
            r_flush_cnt <= LP_FLUSH_LOAD;
            if (w_acc_trap) begin
               r_trap_pc <= w_acc_ex_pc;
            end
            if (r_count != {CountWidth{1'b1}}) begin
               r_count <= r_count + 1'b1;
            end
         end else if (!i_stall) begin
            r_pc <= r_pc + 32'd4;
            if (r_state == S_FLUSH) begin
               r_flush_cnt <= r_flush_cnt - 3'd1;
            end
         end
         if (w_latch) begin
            r_pend_pc    <= w_dest;
            r_pend_ex_pc <= i_ex_pc;
            r_pend_trap  <= w_misaligned;
         end
      end
   end

   assign o_pc             = r_pc;
   assign o_trap           = r_trap;
   assign o_trap_pc        = r_trap_pc;
   assign o_redirect_count = r_count;

endmodule

// File: tb/tb_pc_redirect.sv
// Bench for pc_redirect: directed walk through the redirect scenarios, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pc_redirect;

   localparam logic [31:0] RV = 32'h0000_2000;
   localparam logic [31:0] TV = 32'h0000_0100;
   localparam int          FC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        valid = 1'b0;
   logic        br = 1'b0;
   logic        jal = 1'b0;
   logic        jalr = 1'b0;
   logic        div = 1'b0;
   logic [31:0] ex_pc = 32'h0;
   logic [31:0] ex_imm = 32'h0;
   logic [31:0] ex_rs1 = 32'h0;

   logic [31:0] pc, trap_pc, pc_b, trap_pc_b;
   logic        flush, trap, flush_b, trap_b;
   logic [15:0] cnt;
   logic [1:0]  cnt_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_redirect #(.ResetVector(RV), .TrapVector(TV), .FlushCycles(FC), .CountWidth(16)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_stall(stall), .i_ex_valid(valid),
      .i_ex_is_branch(br), .i_ex_is_jal(jal), .i_ex_is_jalr(jalr), .i_diverge(div),
      .i_ex_pc(ex_pc), .i_ex_imm(ex_imm), .i_ex_rs1(ex_rs1),
      .o_pc(pc), .o_flush(flush), .o_trap(trap), .o_trap_pc(trap_pc), .o_redirect_count(cnt)
   );

   pc_redirect #(.ResetVector(RV), .TrapVector(TV), .FlushCycles(FC), .CountWidth(2)) dut_sat (
      .i_clock(clk), .i_reset_n(rst_n), .i_stall(stall), .i_ex_valid(valid),
      .i_ex_is_branch(br), .i_ex_is_jal(jal), .i_ex_is_jalr(jalr), .i_diverge(div),
      .i_ex_pc(ex_pc), .i_ex_imm(ex_imm), .i_ex_rs1(ex_rs1),
      .o_pc(pc_b), .o_flush(flush_b), .o_trap(trap_b), .o_trap_pc(trap_pc_b), .o_redirect_count(cnt_b)
   );

   typedef struct {
      logic [31:0] pc;
      int          flush_left;
      bit          pending;
      logic [31:0] p_dest;
      bit          p_trap;
      logic [31:0] p_expc;
      bit          trap;
      logic [31:0] trap_pc;
      int          total;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.pc = RV; r.flush_left = 0; r.pending = 0; r.p_dest = 0; r.p_trap = 0;
      r.p_expc = 0; r.trap = 0; r.trap_pc = 0; r.total = 0;
      return r;
   endfunction

   // One clock edge of the architectural behaviour, from the current inputs
   function automatic model_t model_step(model_t s);
      model_t      n = s;
      bit          req, trapf, acc;
      logic [31:0] tgt, dest, a_dest, a_expc;
      bit          a_trap;
      n.trap = 0;
      acc = 0; a_dest = 0; a_expc = 0; a_trap = 0;
      req = valid && ((br && div) || jal || jalr);
      tgt = jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
      trapf = (tgt % 4) != 0;
      dest = trapf ? TV : tgt;
      if (s.pending) begin
         if (!stall) begin acc = 1; a_dest = s.p_dest; a_trap = s.p_trap; a_expc = s.p_expc; end
      end else if (s.flush_left > 0) begin
         if (!stall) begin n.pc = s.pc + 4; n.flush_left = s.flush_left - 1; end
      end else if (req) begin
         if (stall) begin
            n.pending = 1; n.p_dest = dest; n.p_trap = trapf; n.p_expc = ex_pc;
         end else begin
            acc = 1; a_dest = dest; a_trap = trapf; a_expc = ex_pc;
         end
      end else if (!stall) begin
         n.pc = s.pc + 4;
      end
      if (acc) begin
         n.pending = 0; n.pc = a_dest; n.flush_left = FC; n.total = s.total + 1;
         if (a_trap) begin n.trap = 1; n.trap_pc = a_expc; end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_step(m);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      check("pc", pc, m.pc);
      check("flush", 32'(flush), 32'(m.flush_left > 0));
      check("trap", 32'(trap), 32'(m.trap));
      check("trap_pc", trap_pc, m.trap_pc);
      check("count", 32'(cnt), (m.total > 65535) ? 32'd65535 : 32'(m.total));
      check("count_sat", 32'(cnt_b), (m.total > 3) ? 32'd3 : 32'(m.total));
      check("pc_sat_inst", pc_b, m.pc);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_idle();
      valid = 0; br = 0; jal = 0; jalr = 0; div = 0;
   endtask

   task automatic rand_ex();
      logic [31:0] t;
      int          sel;
      valid = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      br   = (sel <= 3) || (sel == 9);
      jal  = (sel == 4) || (sel == 5) || (sel == 9);
      jalr = (sel == 6) || (sel == 7) || (sel == 9);
      div  = 1'($urandom_range(0, 1));
      t = $urandom(); ex_pc = t & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) ex_imm = $urandom();
      else ex_imm = ($urandom() & 32'h0000_0FFC) - 32'h0000_0800;
      t = $urandom();
      ex_rs1 = ($urandom_range(0, 5) == 0) ? t : (t & 32'hFFFF_FFFC);
   endtask

   initial begin
      // reset and free-running fetch
      repeat (2) @(negedge clk);
      check("rst_pc", pc, 32'h2000);
      check("rst_flush", 32'(flush), 32'h0);
      check("rst_count", 32'(cnt), 32'h0);
      rst_n = 1;
      repeat (3) tick();
      check("run_pc", pc, 32'h200C);
      $display("[TB] release reset pc=%h", pc);

      // taken branch, backwards
      valid = 1; br = 1; div = 1; ex_pc = 32'h2040; ex_imm = 32'hFFFF_FFF0;
      tick();
      check("br_pc", pc, 32'h2030);
      check("br_flush", 32'(flush), 32'h1);
      check("br_count", 32'(cnt), 32'h1);
      set_idle(); tick();
      check("br_flush2", 32'(flush), 32'h1);
      tick();
      check("br_flush_end", 32'(flush), 32'h0);
      check("br_pc_after", pc, 32'h2038);
      $display("[TB] taken branch pc=%h count=%0d", pc, cnt);

      // same branch, not taken
      valid = 1; br = 1; div = 0;
      tick();
      check("nt_pc", pc, 32'h203C);
      check("nt_flush", 32'(flush), 32'h0);
      $display("[TB] not-taken branch pc=%h", pc);

      // JALR aligned then misaligned
      set_idle(); valid = 1; jalr = 1; ex_rs1 = 32'h3001; ex_imm = 32'h4;
      tick();
      check("jalr_pc", pc, 32'h3004);
      set_idle(); repeat (2) tick();
      valid = 1; jalr = 1; ex_rs1 = 32'h3002; ex_imm = 32'h4; ex_pc = 32'h5550;
      tick();
      check("trap_pc_val", pc, 32'h100);
      check("trap_pulse", 32'(trap), 32'h1);
      check("trap_expc", trap_pc, 32'h5550);
      set_idle(); tick();
      check("trap_once", 32'(trap), 32'h0);
      tick();
      $display("[TB] jalr trap trap_pc=%h count=%0d", trap_pc, cnt);

      // JAL arriving under a 3-cycle stall
      valid = 1; jal = 1; ex_pc = 32'h3F00; ex_imm = 32'h100; stall = 1;
      tick();
      for (int i = 0; i < 2; i++) begin rand_ex(); tick(); end
      check("stall_hold", pc, 32'h108);
      check("stall_noflush", 32'(flush), 32'h0);
      rand_ex(); stall = 0;
      tick();
      check("pend_pc", pc, 32'h4000);
      check("pend_flush", 32'(flush), 32'h1);
      check("pend_count", 32'(cnt), 32'h4);
      set_idle(); repeat (2) tick();
      $display("[TB] stalled jal pc=%h", pc);

      // stall and ignored request inside FLUSH
      valid = 1; jal = 1; ex_pc = 32'h4FF0; ex_imm = 32'h10;
      tick();
      ex_pc = 32'h6000; ex_imm = 32'h0; stall = 1;
      repeat (2) tick();
      check("fl_stall_pc", pc, 32'h5000);
      check("fl_stall_flush", 32'(flush), 32'h1);
      stall = 0;
      tick();
      check("fl_stretch", 32'(flush), 32'h1);
      tick();
      check("fl_end", 32'(flush), 32'h0);
      check("fl_pc", pc, 32'h5008);
      check("fl_count", 32'(cnt), 32'h5);
      $display("[TB] flush stretch pc=%h count=%0d", pc, cnt);

      // PC wrap and saturating counter
      set_idle(); valid = 1; jalr = 1; ex_rs1 = 32'hFFFF_FFF8; ex_imm = 32'h4;
      tick();
      check("wrap_pre", pc, 32'hFFFF_FFFC);
      set_idle(); tick();
      check("wrap_pc", pc, 32'h0);
      check("sat_count", 32'(cnt_b), 32'h3);
      tick();
      $display("[TB] wrap pc=%h sat_count=%0d", pc, cnt_b);

      // asynchronous reset mid-FLUSH
      valid = 1; jal = 1; ex_pc = 32'h2000; ex_imm = 32'hC;
      tick();
      set_idle(); tick();
      check("mid_pc", pc, 32'h2010);
      #2 rst_n = 0;
      #1;
      check("async_pc", pc, 32'h2000);
      check("async_flush", 32'(flush), 32'h0);
      check("async_count", 32'(cnt), 32'h0);
      @(negedge clk) rst_n = 1;
      $display("[TB] async reset pc=%h", pc);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n = 1;
         stall = ($urandom_range(0, 3) == 0);
         rand_ex();
         tick();
         if ($urandom_range(0, 299) == 0) #2 rst_n = 0;
      end
      rst_n = 1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
